// File: rtl/kbd_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kbd_arb_pkg                                                              |
// | Shared register map, status bit positions and source encoding for the    |
// | keyboard source arbiter.                                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package kbd_arb_pkg;

    localparam logic KBD_REG_DATA = 1'b0;
    localparam logic KBD_REG_STAT = 1'b1;

    localparam int STAT_RDY = 7;
    localparam int STAT_OVF = 6;

    typedef enum logic {
        SRC_PS2  = 1'b0,
        SRC_UART = 1'b1
    } kbd_src_e;

    // Folds 'a'..'z' onto 'A'..'Z'; all other codes pass through.
    function automatic logic [7:0] kbd_upcase(input logic [7:0] b);
        if (b >= 8'h61 && b <= 8'h7A) begin
            return b - 8'h20;
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kbd_fifo                                                                 |
// | Power-of-two byte FIFO with a combinational head and an occupancy count. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module kbd_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk25,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
    always_comb begin
        do_rd    = rd_en & (count_q != '0);
        do_wr    = wr_en & ((count_q != FULL_COUNT) | do_rd);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
        count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk25) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/kbd_source_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kbd_source_arbiter                                                       |
// | Merges PS/2 and UART ASCII bytes into one Apple-1 keyboard register pair |
// | via per-source holding registers, a round-robin arbiter and a FIFO.      |
// | Define KBD_ARB_UPCASE_EN to fold lowercase letters on FIFO write.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module kbd_source_arbiter
    import kbd_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic [7:0] ps2_data,
    input  logic       ps2_valid,
    input  logic [7:0] uart_data,
    input  logic       uart_valid,
    input  logic       cs,
    input  logic       address,
    output logic [7:0] dout
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0] ps2_hold_q, ps2_hold_d;
    logic       ps2_hv_q, ps2_hv_d;
    logic [7:0] uart_hold_q, uart_hold_d;
    logic       uart_hv_q, uart_hv_d;
    kbd_src_e   rr_last_q, rr_last_d;
    logic       ovf_q, ovf_d;
    logic [7:0] last_popped_q, last_popped_d;
    logic [7:0] dout_q, dout_d;

    logic       fifo_empty, fifo_full;
    logic [7:0] fifo_rd_data;
    logic [PTR_W:0] fifo_count;
    logic       count_unused;

    logic       pop, write_ok, stat_rd, ovf_evt;
    logic       grant_ps2, grant_uart, push;
    logic [7:0] push_raw, push_byte, stat_word;

    always_comb begin
        pop      = cs && (address == KBD_REG_DATA) && !fifo_empty;
        stat_rd  = cs && (address == KBD_REG_STAT);
        write_ok = !fifo_full || pop;

        grant_ps2  = write_ok && ps2_hv_q  && (!uart_hv_q || rr_last_q == SRC_UART);
        grant_uart = write_ok && uart_hv_q && (!ps2_hv_q  || rr_last_q == SRC_PS2);
        push       = grant_ps2 || grant_uart;
        push_raw   = grant_ps2 ? ps2_hold_q : uart_hold_q;
`ifdef KBD_ARB_UPCASE_EN
        push_byte  = kbd_upcase(push_raw);
`else
        push_byte  = push_raw;
`endif

        // The pointer only moves on a contested grant, so a lone source never steals the next tie.
        rr_last_d = rr_last_q;
        if (grant_ps2 && uart_hv_q) begin
            rr_last_d = SRC_PS2;
        end
        if (grant_uart && ps2_hv_q) begin
            rr_last_d = SRC_UART;
        end

        ovf_evt    = 1'b0;
        ps2_hold_d = ps2_hold_q;
        ps2_hv_d   = ps2_hv_q & ~grant_ps2;
        if (ps2_valid) begin
            ovf_evt    = ps2_hv_d;
            ps2_hold_d = ps2_data;
            ps2_hv_d   = 1'b1;
        end

        uart_hold_d = uart_hold_q;
        uart_hv_d   = uart_hv_q & ~grant_uart;
        if (uart_valid) begin
            ovf_evt     = ovf_evt | uart_hv_d;
            uart_hold_d = uart_data;
            uart_hv_d   = 1'b1;
        end

        ovf_d         = (ovf_q & ~stat_rd) | ovf_evt;
        last_popped_d = pop ? fifo_rd_data : last_popped_q;

        stat_word           = 8'h00;
        stat_word[STAT_RDY] = !fifo_empty;
        stat_word[STAT_OVF] = ovf_q;

        dout_d = dout_q;
        if (stat_rd) begin
            dout_d = stat_word;
        end else if (cs) begin
            dout_d = fifo_empty ? {1'b1, last_popped_q[6:0]} : {1'b1, fifo_rd_data[6:0]};
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            ps2_hold_q    <= 8'h00;
            ps2_hv_q      <= 1'b0;
            uart_hold_q   <= 8'h00;
            uart_hv_q     <= 1'b0;
            rr_last_q     <= SRC_UART;
            ovf_q         <= 1'b0;
            last_popped_q <= 8'h00;
            dout_q        <= 8'h00;
        end else begin
            ps2_hold_q    <= ps2_hold_d;
            ps2_hv_q      <= ps2_hv_d;
            uart_hold_q   <= uart_hold_d;
            uart_hv_q     <= uart_hv_d;
            rr_last_q     <= rr_last_d;
            ovf_q         <= ovf_d;
            last_popped_q <= last_popped_d;
            dout_q        <= dout_d;
        end
    end

    kbd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk25   (clk25),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (push_byte),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign count_unused = ^fifo_count;
    assign dout         = dout_q;

endmodule
`default_nettype wire
